e_mdu: RTL
==========

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Sits beside the execute ALU and takes the same forwarded rs/rt operands.
- Its read result (MFHI/MFLO) is muxed with the ALU result into the E/M pipeline register.
- Owns HI/LO and models multi-cycle latency with a busy flag that the hazard unit uses to stall D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- E_data1  input  32  rs operand, forwarded
- E_data2  input  32  rt operand, forwarded
- E_md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9–11 reserved (see optional feature)
- E_start  input  1  one-cycle pulse, asserted when a MULT/MULTU/DIV/DIVU instruction is in E
- E_busy  output  1  computation in flight
- E_md_out  output  32  HI for MFHI, LO for MFLO, else 0 (combinational)
- E_hi  output  32  current HI register
- E_lo  output  32  current LO register

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, pending results=0. Reset mid-operation aborts the operation; HI/LO stay 0.
- State machine has two states:
  - IDLE to RUN: E_start=1 with op in {MULT, MULTU, DIV, DIVU} at a clock edge. That edge latches the computed result into a pending hi/lo pair and loads the counter with MULT_CYCLES or DIV_CYCLES.
  - RUN: counter decrements each edge. At the edge where counter==1, pending values are written to HI/LO and the state returns to IDLE.
- Busy timing: E_busy is registered, 0 during the E_start cycle, 1 for exactly N following cycles. New HI/LO values are visible the cycle E_busy falls.
- Arithmetic:
  - MULT: {HI,LO} = signed 32×32 → 64.
  - MULTU: {HI,LO} = unsigned 32×32 → 64.
  - DIV: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
  - Divide by zero: busy sequence still runs; HI/LO unchanged at completion.
- MTHI/MTLO: write E_data1 into HI/LO at the next edge, no busy. Ignored while busy.
- MFHI/MFLO: read current HI/LO combinationally. While busy, the old value is returned; the hazard unit guarantees no MF issues while busy or start.
- E_start with op not in the start set: ignored.
- E_start while busy: ignored, no restart.
- Stall contract, owned by the hazard unit and documented here: stall D if D holds any MDU op and (E_start | E_busy).

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, ops 9 MADD, 10 MADDU and 11 MSUB are start ops with MULT_CYCLES latency.
  - MADD: {HI,LO} += signed product.
  - MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} −= signed product.
  - Accumulation uses HI/LO as of the E_start edge; 64-bit wrap-around, no overflow flag.
- When undefined, ops 9–11 are treated as NONE: E_start ignored, E_md_out=0.

Decomposition:
- Shared package/header holds:
  - MD_NONE … MD_MSUB op encodings, also used by the decoder and hazard unit.
  - MDU_OP_W=4.
  - Default latency constants.
- One natural sub-module, e_mdu_calc: purely combinational 64-bit result generator (op, a, b, hi, lo → pending hi/lo). The top keeps the FSM, counter and registers.

Test Plan:
- MULT a=0xFFFFFFFE (−2), b=3; E_start pulse → E_busy high cycles 1–5, low at cycle 6; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU a=7, b=2 → busy exactly 10 cycles, then LO=3, HI=1. DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI 0x12345678 then MFHI next cycle → E_md_out=0x12345678, busy never asserted. DIV by 0 after that → HI still 0x12345678.
- During busy:
  - start MULTU 5×5 during busy of a DIV → ignored;
  - MTLO 0xAA while busy → LO unaffected;
  - final HI/LO reflect only the DIV.
- Pull reset low at cycle 3 of a MULT (async, mid-clock) → E_busy, HI and LO drop to 0 immediately; no write after release.
- With MDU_MADD_EN: HI:LO=0:0xFFFFFFFF, MADDU 1×1 → HI=1, LO=0 after 5 cycles. Without it: op 9 with E_start → busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared op encodings and latency defaults for the execute-stage multiply/divide unit.
// Ops 9-11 (MADD/MADDU/MSUB) are start ops only when MDU_MADD_EN is defined.
package e_mdu_pkg;

  localparam int unsigned MDU_OP_W        = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  function automatic logic is_start_op(input logic [MDU_OP_W-1:0] op);
    logic res;
    res = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB:         res = 1'b1;
`endif
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Execute-stage <-> MDU signal bundle: forwarded operands, op/start in, busy and results out.
interface e_mdu_if;
  logic [31:0]                     E_data1;
  logic [31:0]                     E_data2;
  logic [e_mdu_pkg::MDU_OP_W-1:0]  E_md_op;
  logic                            E_start;
  logic                            E_busy;
  logic [31:0]                     E_md_out;
  logic [31:0]                     E_hi;
  logic [31:0]                     E_lo;

  modport master (
    output E_data1, E_data2, E_md_op, E_start,
    input  E_busy, E_md_out, E_hi, E_lo
  );

  modport slave (
    input  E_data1, E_data2, E_md_op, E_start,
    output E_busy, E_md_out, E_hi, E_lo
  );
endinterface

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit HI/LO result generator; divide by zero returns HI/LO unchanged.
// MADD/MADDU/MSUB accumulation is compiled in only with MDU_MADD_EN.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [31:0]         hi_i,
  input  logic [31:0]         lo_i,
  output logic [31:0]         hi_o,
  output logic [31:0]         lo_o
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        acc;
  logic [63:0]        res;
  logic signed [31:0] sa, sb, sq, sr;

  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'b0, a_i} * {32'b0, b_i};
    acc    = {hi_i, lo_i};
    sa     = $signed(a_i);
    sb     = $signed(b_i);
    sq     = '0;
    sr     = '0;
    res    = acc;
    case (op_i)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (b_i != '0) begin
          // Most-negative / -1 overflows 32 bits; pin the architected result.
          if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
            res = {32'h0, 32'h8000_0000};
          end else begin
            sq  = sa / sb;
            sr  = sa % sb;
            res = {sr, sq};
          end
        end
      end
      MD_DIVU: begin
        if (b_i != '0) res = {a_i % b_i, a_i / b_i};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  res = acc + prod_s;
      MD_MADDU: res = acc + prod_u;
      MD_MSUB:  res = acc - prod_s;
`endif
      default:  res = acc;
    endcase
    hi_o = res[63:32];
    lo_o = res[31:0];
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, models latency with a busy countdown.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  mdu
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        calc_hi, calc_lo;

  e_mdu_calc u_calc (
    .op_i (mdu.E_md_op),
    .a_i  (mdu.E_data1),
    .b_i  (mdu.E_data2),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (calc_hi),
    .lo_o (calc_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        // Result is computed at the start edge; the countdown only models latency.
        if (mdu.E_start && is_start_op(mdu.E_md_op)) begin
          state_d   = ST_RUN;
          cnt_d     = is_div_op(mdu.E_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
        end else if (mdu.E_md_op == MD_MTHI) begin
          hi_d = mdu.E_data1;
        end else if (mdu.E_md_op == MD_MTLO) begin
          lo_d = mdu.E_data1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mdu.E_busy = (state_q == ST_RUN);
    mdu.E_hi   = hi_q;
    mdu.E_lo   = lo_q;
    case (mdu.E_md_op)
      MD_MFHI: mdu.E_md_out = hi_q;
      MD_MFLO: mdu.E_md_out = lo_q;
      default: mdu.E_md_out = '0;
    endcase
  end

endmodule
